// File: rtl/twiddle_gen.sv
// Radix-2 DIT FFT twiddle sequencer: walks every (stage, butterfly) pair and emits
// the 8-bit (cos, -sin) coefficient from a 17-entry quarter-wave ROM.
module twiddle_gen #(
    parameter int LOG2N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] tw_re,
    output logic [7:0] tw_im,
    output logic       tw_valid,
    output logic [2:0] stage,
    output logic [4:0] bfly,
    output logic       busy,
    output logic       done
);
    localparam int         N      = 1 << LOG2N;
    localparam logic [4:0] J_LAST = 5'(N / 2 - 1);
    localparam logic [2:0] S_LAST = 3'(LOG2N - 1);

    // Handshake: a twiddle is accepted on a rising edge where tw_valid=1 and stall=0;
    // while stall=1 every counter and output register holds its value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [2:0] s_nx;
    logic [4:0] j_nx;
    logic       load;
    logic [4:0] mask;
    logic [4:0] m;
    logic [7:0] cos_v, sin_v;
    logic [7:0] re_nx, im_nx;

    function automatic logic [7:0] qrom(input logic [4:0] idx);
        logic [7:0] q;
        case (idx)
            5'd0:    q = 8'd127;
            5'd1:    q = 8'd126;
            5'd2:    q = 8'd125;
            5'd3:    q = 8'd122;
            5'd4:    q = 8'd117;
            5'd5:    q = 8'd112;
            5'd6:    q = 8'd106;
            5'd7:    q = 8'd98;
            5'd8:    q = 8'd90;
            5'd9:    q = 8'd81;
            5'd10:   q = 8'd71;
            5'd11:   q = 8'd60;
            5'd12:   q = 8'd49;
            5'd13:   q = 8'd37;
            5'd14:   q = 8'd25;
            5'd15:   q = 8'd12;
            default: q = 8'd0;
        endcase
        return q;
    endfunction

    // State register; twiddle, stage and bfly registers load only on a new twiddle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            stage <= 3'd0;
            bfly  <= 5'd0;
            tw_re <= 8'd0;
            tw_im <= 8'd0;
        end else begin
            state <= state_nx;
            if (load) begin
                stage <= s_nx;
                bfly  <= j_nx;
                tw_re <= re_nx;
                tw_im <= im_nx;
            end
        end
    end

    // Next-state and counter advance.
    always_comb begin
        state_nx = state;
        s_nx     = stage;
        j_nx     = bfly;
        load     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    s_nx     = 3'd0;
                    j_nx     = 5'd0;
                    load     = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (bfly == J_LAST) begin
                        if (stage == S_LAST) begin
                            state_nx = ST_DONE;
                        end else begin
                            s_nx = stage + 3'd1;
                            j_nx = 5'd0;
                            load = 1'b1;
                        end
                    end else begin
                        j_nx = bfly + 5'd1;
                        load = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs: status flags decode the state register; the twiddle for the next
    // (s, j) is looked up here and captured by the register above.
    always_comb begin
        tw_valid = (state == ST_RUN);
        busy     = (state == ST_RUN);
        done     = (state == ST_DONE);
        // m = k*64/N collapses to (j mod 2^s) << (5-s), independent of N.
        mask     = (5'd1 << s_nx) - 5'd1;
        m        = (j_nx & mask) << (3'd5 - s_nx);
        if (m <= 5'd16) begin
            cos_v = qrom(m);
            sin_v = qrom(5'd16 - m);
        end else begin
            cos_v = 8'd0 - qrom(5'(6'd32 - {1'b0, m}));
            sin_v = qrom(m - 5'd16);
        end
        re_nx = cos_v;
        im_nx = 8'd0 - sin_v;
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: N=16 full-sequence scoreboard with stall, mid-run
// start, mid-run reset and back-to-back runs; N=64 spot checks of the last stage.
module tb_twiddle_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, stall4, start6, stall6;
    logic [7:0] re4, im4, re6, im6;
    logic       valid4, busy4, done4, valid6, busy6, done6;
    logic [2:0] stage4, stage6;
    logic [4:0] bfly4, bfly6;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Hand-computed (cos, -sin) for N=16, k=0..7.
    logic [7:0] re16 [8] = '{8'h7F, 8'h75, 8'h5A, 8'h31, 8'h00, 8'hCF, 8'hA6, 8'h8B};
    logic [7:0] im16 [8] = '{8'h00, 8'hCF, 8'hA6, 8'h8B, 8'h81, 8'h8B, 8'hA6, 8'hCF};

    twiddle_gen #(.LOG2N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stall(stall4),
        .tw_re(re4), .tw_im(im4), .tw_valid(valid4), .stage(stage4),
        .bfly(bfly4), .busy(busy4), .done(done4)
    );

    twiddle_gen #(.LOG2N(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .stall(stall6),
        .tw_re(re6), .tw_im(im6), .tw_valid(valid6), .stage(stage6),
        .bfly(bfly6), .busy(busy6), .done(done6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_q16();
        exp_q.delete();
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 8; j++) begin
                int k;
                k = (j % (1 << s)) * (8 >> s);
                exp_q.push_back({8'h00, 3'(s), 5'(j), re16[k], im16[k]});
            end
        end
    endtask

    // One full N=16 sequence; optional 3-cycle stall at (1,3) and a start pulse in stage 2.
    task automatic stream4(input string tag, input int stall_len, input bit pulse_mid,
                           input int exp_done);
        int acc, ndone, done_c, stalled;
        bit pulsed;
        acc = 0; ndone = 0; done_c = 0; stalled = 0; pulsed = 0;
        fill_q16();
        @(negedge clk);
        start4 = 1'b1;
        stall4 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_c != 0) begin
                check({tag, "_done_low"}, 32'(done4), 32'd0);
                break;
            end
            if (valid4) begin
                if (exp_q.size() == 0) check({tag, "_extra_beat"}, 32'd1, 32'd0);
                else check({tag, "_beat"}, {8'h00, stage4, bfly4, re4, im4}, exp_q[0]);
            end
            if (done4) begin
                ndone++;
                done_c = c;
                check({tag, "_done_flags"}, {30'd0, valid4, busy4}, 32'd0);
            end
            start4 = 1'b0;
            stall4 = 1'b0;
            if (valid4 && stalled < stall_len && stage4 == 3'd1 && bfly4 == 5'd3) begin
                stall4 = 1'b1;
                stalled++;
            end
            if (valid4 && pulse_mid && !pulsed && stage4 == 3'd2) begin
                start4 = 1'b1;
                pulsed = 1'b1;
            end
            if (valid4 && !stall4) begin
                acc++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        start4 = 1'b0;
        stall4 = 1'b0;
        check({tag, "_beats"}, 32'(acc), 32'd32);
        check({tag, "_done_at"}, 32'(done_c), 32'(exp_done));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
    endtask

    initial begin
        int hit, n6, d6, spots;
        rst_n = 1'b0; start4 = 1'b0; stall4 = 1'b0; start6 = 1'b0; stall6 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_n16", {re4, im4, stage4, bfly4, valid4, busy4, done4}, 32'd0);
        check("reset_n64", {re6, im6, stage6, bfly6, valid6, busy6, done6}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        stream4("plain", 0, 1'b0, 33);
        stream4("stall", 3, 1'b0, 36);
        stream4("midstart", 0, 1'b1, 33);

        // Reset in the middle of stage 2, then a fresh run must replay from (0,0).
        @(negedge clk);
        start4 = 1'b1;
        hit = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (valid4 && stage4 == 3'd2 && bfly4 == 5'd5) begin
                hit = 1;
                break;
            end
        end
        check("rst_reached", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_outputs", {re4, im4, stage4, bfly4, valid4, busy4, done4}, 32'd0);
        stream4("replay", 0, 1'b0, 33);

        // start held high: two sequences separated by a single done cycle.
        @(negedge clk);
        check("b2b_idle_before", 32'(busy4), 32'd0);
        start4 = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            check("b2b_valid", 32'(valid4), 32'(c != 33 && c != 66));
            check("b2b_done", 32'(done4), 32'(c == 33 || c == 66));
            if (c == 34) check("b2b_restart", {24'd0, stage4, bfly4, 8'h00} | {16'd0, re4, im4},
                               {24'd0, 8'h00} | 32'h7F00);
        end
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_idle_after", {30'd0, valid4, busy4}, 32'd0);

        // N=64: spot values on the last stage and total beat count.
        n6 = 0; d6 = 0; spots = 0;
        @(negedge clk);
        start6 = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            start6 = 1'b0;
            if (valid6) n6++;
            if (valid6 && stage6 == 3'd0 && bfly6 == 5'd0)
                check("n64_first", {16'd0, re6, im6}, 32'h7F00);
            if (valid6 && stage6 == 3'd5) begin
                case (bfly6)
                    5'd1:  begin check("n64_k1",  {16'd0, re6, im6}, 32'h7EF4); spots++; end
                    5'd8:  begin check("n64_k8",  {16'd0, re6, im6}, 32'h5AA6); spots++; end
                    5'd31: begin check("n64_k31", {16'd0, re6, im6}, 32'h82F4); spots++; end
                    default: ;
                endcase
            end
            if (done6) begin
                d6 = c;
                break;
            end
        end
        check("n64_beats", 32'(n6), 32'd192);
        check("n64_done_at", 32'(d6), 32'd193);
        check("n64_spots", 32'(spots), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
